// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath: instruction field
// positions and the opcode encoding seen by the control unit.
package cpu_pkg;

    localparam int OPC_W_DEFAULT = 4;
    localparam int RA_LSB        = 2;
    localparam int RB_LSB        = 0;

    // Opcode field of the 8-bit ISA; ALU operations occupy the upper half.
    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_DATA  = 4'h2,
        OP_JMPR  = 4'h3,
        OP_JMP   = 4'h4,
        OP_JCAF  = 4'h5,
        OP_CLF   = 4'h6,
        OP_ADD   = 4'h8,
        OP_SHR   = 4'h9,
        OP_SHL   = 4'hA,
        OP_NOT   = 4'hB,
        OP_AND   = 4'hC,
        OP_OR    = 4'hD,
        OP_XOR   = 4'hE,
        OP_CMP   = 4'hF
    } opcode_e;

endpackage

// File: rtl/ir_fifo.sv
// Prefetch storage for ir_prefetch_queue: a DEPTH-entry circular buffer
// with read/write pointers and an occupancy count. The head entry is
// read combinationally so the IR can load it in the same cycle.
module ir_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a small prefetch queue. The fetch side
// pushes words with valid/ready; the stepper consumes the IR with advance.
// When the queue is empty a pushed word bypasses straight into the IR.
// flush (taken jump) discards the IR and all queued words.
// Optional feature macro: IR_PARITY_EN adds an even-parity bit per entry
// and a registered parity_err output.
module ir_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OPC_W = OPC_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             i_in,
    input  logic                         advance,
    input  logic                         flush,
    output logic [WIDTH-1:0]             i_out,
    output logic                         ir_valid,
    output logic [OPC_W-1:0]             opc,
    output logic [1:0]                   ra,
    output logic [1:0]                   rb,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IR_PARITY_EN
    ,
    output logic                         parity_err
`endif
);

`ifdef IR_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] fifo_rdata;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] load_entry;
    logic          push_acc;
    logic          load_slot;
    logic          bypass;
    logic          fifo_push;
    logic          fifo_pop;
    logic          ir_load;

`ifdef IR_PARITY_EN
    assign entry_in = {^i_in, i_in};
`else
    assign entry_in = i_in;
`endif

    // Handshake and load steering; flush blocks push, pop and IR load.
    always_comb begin
        in_ready   = !fifo_full && !flush;
        push_acc   = in_valid && in_ready;
        load_slot  = !ir_valid || advance;
        bypass     = load_slot && fifo_empty && push_acc;
        fifo_push  = push_acc && !bypass;
        fifo_pop   = !flush && load_slot && !fifo_empty;
        ir_load    = !flush && load_slot && (!fifo_empty || push_acc);
        load_entry = fifo_empty ? entry_in : fifo_rdata;
    end

    ir_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (entry_in),
        .rdata (fifo_rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // IR register: flush wins, else reload whenever the slot opens up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_out    <= '0;
            ir_valid <= 1'b0;
        end else if (flush) begin
            ir_valid <= 1'b0;
        end else if (load_slot) begin
            if (ir_load) begin
                i_out    <= load_entry[WIDTH-1:0];
                ir_valid <= 1'b1;
            end else begin
                ir_valid <= 1'b0;
            end
        end
    end

`ifdef IR_PARITY_EN
    // Parity check on every IR load; stored word plus bit must XOR to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (flush) begin
            parity_err <= 1'b0;
        end else if (ir_load) begin
            parity_err <= ^load_entry;
        end
    end
`endif

    assign opc = i_out[WIDTH-1 -: OPC_W];
    assign ra  = i_out[RA_LSB +: 2];
    assign rb  = i_out[RB_LSB +: 2];

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Testbench for ir_prefetch_queue: directed stimulus with a scoreboard of
// expected consumed words, checked by an independent monitor whenever the
// stepper consumes a live IR word.
module tb_ir_prefetch_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] i_in = 8'h00;
    logic       advance = 1'b0;
    logic       flush = 1'b0;
    logic       in_ready;
    logic [7:0] i_out;
    logic       ir_valid;
    logic [3:0] opc;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [2:0] count;
`ifdef IR_PARITY_EN
    logic       parity_err;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;

    ir_prefetch_queue #(.WIDTH(8), .DEPTH(4), .OPC_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .i_in       (i_in),
        .advance    (advance),
        .flush      (flush),
        .i_out      (i_out),
        .ir_valid   (ir_valid),
        .opc        (opc),
        .ra         (ra),
        .rb         (rb),
        .count      (count)
`ifdef IR_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumption of a live IR word is compared to the scoreboard.
    always @(negedge clk) begin
        if (!reset && ir_valid && advance && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL consume_unexpected got=%0h expected=none t=%0t", i_out, $time);
            end else begin
                mon_exp = sb.pop_front();
                check("consume", {24'h0, i_out}, {24'h0, mon_exp});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst_i_out", {24'h0, i_out}, 32'h0);
        check("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
        check("rst_count", {29'h0, count}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // 1: bypass push into empty IR
        in_valid = 1'b1; i_in = 8'h21;
        cyc();
        in_valid = 1'b0;
        check("t1_i_out", {24'h0, i_out}, 32'h21);
        check("t1_ir_valid", {31'h0, ir_valid}, 32'h1);
        check("t1_count", {29'h0, count}, 32'h0);
        check("t1_opc", {28'h0, opc}, 32'h2);
        check("t1_ra", {30'h0, ra}, 32'h0);
        check("t1_rb", {30'h0, rb}, 32'h1);
        sb.push_back(8'h21);
        advance = 1'b1;
        cyc();
        advance = 1'b0;
        check("t1_drained", {31'h0, ir_valid}, 32'h0);

        // 2: fill IR plus full queue, then a held push
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_in = 8'h10 + 8'(i);
            cyc();
        end
        check("t2_i_out", {24'h0, i_out}, 32'h10);
        check("t2_count", {29'h0, count}, 32'h4);
        check("t2_in_ready", {31'h0, in_ready}, 32'h0);
        check("t2_opc", {28'h0, opc}, 32'h1);
        i_in = 8'hEE;
        cyc();
        cyc();
        check("t2_held_count", {29'h0, count}, 32'h4);
        check("t2_held_ready", {31'h0, in_ready}, 32'h0);
        check("t2_held_i_out", {24'h0, i_out}, 32'h10);
        in_valid = 1'b0;

        // 3: drain the full queue one advance at a time
        for (int k = 0; k < 4; k++) begin
            sb.push_back(8'h10 + 8'(k));
            advance = 1'b1;
            cyc();
            check("t3_i_out", {24'h0, i_out}, 32'h11 + k);
            check("t3_count", {29'h0, count}, 32'(3 - k));
            check("t3_in_ready", {31'h0, in_ready}, 32'h1);
        end
        sb.push_back(8'h14);
        cyc();
        advance = 1'b0;
        check("t3_empty_ir", {31'h0, ir_valid}, 32'h0);

        // 4: flush beats push and advance in the same cycle
        in_valid = 1'b1; i_in = 8'hB6;
        cyc();
        check("t4_opc", {28'h0, opc}, 32'hB);
        check("t4_ra", {30'h0, ra}, 32'h1);
        check("t4_rb", {30'h0, rb}, 32'h2);
        i_in = 8'h31;
        cyc();
        i_in = 8'h32;
        cyc();
        check("t4_count_pre", {29'h0, count}, 32'h2);
        i_in = 8'h40; advance = 1'b1; flush = 1'b1;
        #1;
        check("t4_ready_flush", {31'h0, in_ready}, 32'h0);
        cyc();
        in_valid = 1'b0; advance = 1'b0; flush = 1'b0;
        check("t4_ir_valid", {31'h0, ir_valid}, 32'h0);
        check("t4_count", {29'h0, count}, 32'h0);
        cyc();
        check("t4_not_stored", {31'h0, ir_valid}, 32'h0);
        in_valid = 1'b1; i_in = 8'h41;
        cyc();
        in_valid = 1'b0;
        check("t4_after_i_out", {24'h0, i_out}, 32'h41);
        check("t4_after_count", {29'h0, count}, 32'h0);
        sb.push_back(8'h41);
        advance = 1'b1;
        cyc();
        advance = 1'b0;

        // 5: asynchronous reset in the middle of a push burst
        in_valid = 1'b1; i_in = 8'h50;
        cyc();
        i_in = 8'h51;
        cyc();
        i_in = 8'h52;
        #2 reset = 1'b1;
        #1;
        check("t5_i_out", {24'h0, i_out}, 32'h0);
        check("t5_ir_valid", {31'h0, ir_valid}, 32'h0);
        check("t5_count", {29'h0, count}, 32'h0);
        check("t5_in_ready", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

`ifdef IR_PARITY_EN
        // 6: corrupted parity bit in a stored entry
        in_valid = 1'b1; i_in = 8'h60;
        cyc();
        i_in = 8'h61;
        cyc();
        i_in = 8'h62;
        cyc();
        in_valid = 1'b0;
        dut.u_fifo.mem[0][8] = ~dut.u_fifo.mem[0][8];
        check("t6_err_clean", {31'h0, parity_err}, 32'h0);
        sb.push_back(8'h60);
        advance = 1'b1;
        cyc();
        check("t6_i_out_bad", {24'h0, i_out}, 32'h61);
        check("t6_err_set", {31'h0, parity_err}, 32'h1);
        sb.push_back(8'h61);
        cyc();
        advance = 1'b0;
        check("t6_i_out_good", {24'h0, i_out}, 32'h62);
        check("t6_err_clear", {31'h0, parity_err}, 32'h0);
        sb.push_back(8'h62);
        advance = 1'b1;
        cyc();
        advance = 1'b0;
`endif

        cyc();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
